// File: rtl/uart_reg_responder.sv
// Command responder between the UART RX/TX FIFOs and a local register bank ('R' addr / 'W' addr data).
// Define UART_RESP_TIMEOUT_EN to drop partial frames after TIMEOUT idle cycles (pulses frame_to).
module uart_reg_responder #(
    parameter int DBIT    = 8,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_empty,
    input  logic [DBIT-1:0]           r_data,
    output logic                      rd_uart,
    input  logic                      tx_full,
    output logic [DBIT-1:0]           w_data,
    output logic                      wr_uart,
    output logic [(2**AW)*DBIT-1:0]   regs,
    output logic                      nak,
    output logic                      frame_to
);
    localparam int NREG = 2 ** AW;
    localparam logic [DBIT-1:0] CMD_READ  = DBIT'(8'h52);
    localparam logic [DBIT-1:0] CMD_WRITE = DBIT'(8'h57);
    localparam logic [DBIT-1:0] RESP_ACK  = DBIT'(8'h06);
    localparam logic [DBIT-1:0] RESP_NAK  = DBIT'(8'h15);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND} state_t;

    state_t          state_q, state_d;
    logic            is_write_q;
    logic [DBIT-1:0] addr_q;
    logic [DBIT-1:0] data_q;
    logic [DBIT-1:0] w_data_q;
    logic            nak_q;
    logic [DBIT-1:0] reg_q [NREG];
    logic            cmd_ok;
    logic            addr_ok;
    logic            timeout_hit;
    logic [AW-1:0]   reg_idx;

    assign cmd_ok  = (r_data == CMD_READ) || (r_data == CMD_WRITE);
    assign addr_ok = (addr_q >> AW) == '0;
    assign reg_idx = addr_q[AW-1:0];

`ifdef UART_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] idle_cnt_q;
    logic          in_get;

    assign in_get = (state_q == GET_ADDR) || (state_q == GET_DATA);

    // Counts consecutive starved cycles inside a frame; any pop restarts it.
    always_ff @(posedge clk) begin
        if (reset || rd_uart || !in_get) idle_cnt_q <= '0;
        else                              idle_cnt_q <= idle_cnt_q + CW'(1);
    end

    assign timeout_hit = in_get && rx_empty && (idle_cnt_q == CW'(TIMEOUT - 1));
    assign frame_to    = timeout_hit && !reset;
`else
    assign timeout_hit = 1'b0;
    assign frame_to    = 1'b0;
`endif

    // FIFO handshakes: a byte moves on a clk edge only when the flag permits it
    // (rd_uart implies !rx_empty, wr_uart implies !tx_full); both are combinational.
    always_comb begin
        state_d = state_q;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = cmd_ok ? GET_ADDR : SEND;
                end
            end
            GET_ADDR: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = is_write_q ? GET_DATA : EXEC;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = EXEC;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            EXEC: state_d = SEND;
            SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            rd_uart = 1'b0;
            wr_uart = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            w_data_q   <= '0;
            nak_q      <= 1'b0;
            for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            nak_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_uart) begin
                        is_write_q <= (r_data == CMD_WRITE);
                        if (!cmd_ok) begin
                            w_data_q <= RESP_NAK;
                            nak_q    <= 1'b1;
                        end
                    end
                end
                GET_ADDR: if (rd_uart) addr_q <= r_data;
                GET_DATA: if (rd_uart) data_q <= r_data;
                EXEC: begin
                    if (!addr_ok) begin
                        w_data_q <= RESP_NAK;
                        nak_q    <= 1'b1;
                    end else if (is_write_q) begin
                        reg_q[reg_idx] <= data_q;
                        w_data_q       <= RESP_ACK;
                    end else begin
                        w_data_q <= reg_q[reg_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_data = w_data_q;
    assign nak    = nak_q;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
        assign regs[gi*DBIT +: DBIT] = reg_q[gi];
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Bench for uart_reg_responder: FIFO driver, frame-level reference model with per-cycle compare,
// directed scenarios and a randomized frame stream.
`timescale 1ns/1ps
module tb_uart_reg_responder;
    localparam int DBIT = 8;
    localparam int AW   = 4;
    localparam int NREG = 16;
`ifdef UART_RESP_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1000000;
`endif
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAKB = 8'h15;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 rx_empty = 1'b1;
    logic [7:0]           r_data = 8'h00;
    logic                 rd_uart;
    logic                 tx_full = 1'b0;
    logic [7:0]           w_data;
    logic                 wr_uart;
    logic [NREG*DBIT-1:0] regs;
    logic                 nak;
    logic                 frame_to;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         at;
        int         a;
        logic [7:0] d;
    } wr_t;

    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    bit         nak_exp_q[$];
    int         ready_q[$];
    wr_t        vis_wr_q[$];
    logic [7:0] logical_regs[NREG];
    logic [7:0] vis_regs[NREG];
    int         cyc = 0;
    int         starve = 0;
    int         nak_cnt = 0;
    int         to_pulses = 0;

    uart_reg_responder #(.DBIT(DBIT), .AW(AW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .regs     (regs),
        .nak      (nak),
        .frame_to (frame_to)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void add_resp(input logic [7:0] r, input bit is_nak, input int at);
        exp_q.push_back(r);
        nak_exp_q.push_back(is_nak);
        ready_q.push_back(at);
        frame_q.delete();
    endfunction

    // Reference model: parses the popped byte stream into frames and predicts every output.
    always @(negedge clk) begin : compare
        logic [127:0] exp_vec;
        logic         exp_rd;
        logic         exp_wr;
        logic         exp_to;
        cyc++;
        while (vis_wr_q.size() > 0 && vis_wr_q[0].at <= cyc) begin
            vis_regs[vis_wr_q[0].a] = vis_wr_q[0].d;
            void'(vis_wr_q.pop_front());
        end
        for (int i = 0; i < NREG; i++) exp_vec[i*8 +: 8] = vis_regs[i];
        chk("regs", 128'(regs), exp_vec);
        if (reset) begin
            chk("rd_uart_in_reset", 128'(rd_uart), 128'(0));
            chk("wr_uart_in_reset", 128'(wr_uart), 128'(0));
            chk("frame_to_in_reset", 128'(frame_to), 128'(0));
            frame_q.delete();
            exp_q.delete();
            nak_exp_q.delete();
            ready_q.delete();
            vis_wr_q.delete();
            for (int i = 0; i < NREG; i++) begin
                logical_regs[i] = 8'h00;
                vis_regs[i] = 8'h00;
            end
            starve = 0;
            nak_cnt = 0;
        end else begin
            exp_rd = !rx_empty && exp_q.size() == 0;
            chk("rd_uart", 128'(rd_uart), 128'(exp_rd));
            exp_wr = exp_q.size() > 0 && cyc >= ready_q[0] && !tx_full;
            chk("wr_uart", 128'(wr_uart), 128'(exp_wr));
            if (exp_q.size() > 0 && cyc >= ready_q[0]) chk("w_data", 128'(w_data), 128'(exp_q[0]));
            chk("nak_without_response", 128'(nak && exp_q.size() == 0), 128'(0));
            if (nak) nak_cnt++;
            exp_to = 1'b0;
`ifdef UART_RESP_TIMEOUT_EN
            if (frame_q.size() > 0 && rx_empty) begin
                starve++;
                if (starve == TO) exp_to = 1'b1;
            end
`endif
            chk("frame_to", 128'(frame_to), 128'(exp_to));
            if (frame_to) to_pulses++;
            if (exp_to) begin
                frame_q.delete();
                starve = 0;
            end
            if (wr_uart && exp_q.size() > 0) begin
                chk("nak_pulses", 128'(nak_cnt), 128'(nak_exp_q[0] ? 1 : 0));
                void'(exp_q.pop_front());
                void'(nak_exp_q.pop_front());
                void'(ready_q.pop_front());
                nak_cnt = 0;
            end
            if (rd_uart) begin
                starve = 0;
                frame_q.push_back(r_data);
                if (frame_q[0] != 8'h52 && frame_q[0] != 8'h57) begin
                    add_resp(NAKB, 1'b1, cyc + 1);
                end else if (frame_q[0] == 8'h52 && frame_q.size() == 2) begin
                    if (frame_q[1] >= NREG) add_resp(NAKB, 1'b1, cyc + 2);
                    else add_resp(logical_regs[int'(frame_q[1])], 1'b0, cyc + 2);
                end else if (frame_q[0] == 8'h57 && frame_q.size() == 3) begin
                    if (frame_q[1] >= NREG) begin
                        add_resp(NAKB, 1'b1, cyc + 2);
                    end else begin
                        logical_regs[int'(frame_q[1])] = frame_q[2];
                        vis_wr_q.push_back('{cyc + 2, int'(frame_q[1]), frame_q[2]});
                        add_resp(ACK, 1'b0, cyc + 2);
                    end
                end
            end
        end
    end

    task automatic refresh();
        rx_empty = (rx_q.size() == 0);
        r_data = rx_empty ? 8'($urandom) : rx_q[0];
    endtask

    task automatic tick();
        logic       pop;
        logic       push;
        logic [7:0] pd;
        @(negedge clk);
        pop = rd_uart;
        push = wr_uart;
        pd = w_data;
        @(posedge clk);
        #1;
        if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
        if (push) tx_log.push_back(pd);
        refresh();
    endtask

    task automatic feed(input logic [7:0] b);
        rx_q.push_back(b);
        refresh();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((rx_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_wait_expired", 128'(rx_q.size() > 0 || exp_q.size() > 0), 128'(0));
        tick();
    endtask

    initial begin
        logic [7:0] fb[$];
        logic [7:0] b0;
        int         kind;
        int         n0;
        int         p0;
        int         budget;

        reset = 1'b1;
        refresh();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_rd_uart", 128'(rd_uart), 128'(0));
        chk("reset_wr_uart", 128'(wr_uart), 128'(0));
        chk("reset_nak", 128'(nak), 128'(0));
        chk("reset_frame_to", 128'(frame_to), 128'(0));
        chk("reset_w_data", 128'(w_data), 128'(0));
        chk("reset_regs", 128'(regs), 128'(0));

        // Write 0xA5 to reg 3, then read it back
        feed(8'h57); feed(8'h03); feed(8'hA5);
        wait_idle(50);
        chk("write_ack", 128'(tx_log[tx_log.size()-1]), 128'(8'h06));
        chk("write_regs", 128'(regs), 128'h0000_0000_0000_0000_0000_0000_A500_0000);
        feed(8'h52); feed(8'h03);
        wait_idle(50);
        chk("read_back", 128'(tx_log[tx_log.size()-1]), 128'(8'hA5));

        // Unknown command, out-of-range read and write addresses
        feed(8'h41);
        wait_idle(50);
        chk("unknown_cmd_nak", 128'(tx_log[tx_log.size()-1]), 128'(8'h15));
        feed(8'h52); feed(8'h13);
        wait_idle(50);
        chk("bad_read_addr_nak", 128'(tx_log[tx_log.size()-1]), 128'(8'h15));
        feed(8'h57); feed(8'h23); feed(8'h77);
        wait_idle(50);
        chk("bad_write_addr_nak", 128'(tx_log[tx_log.size()-1]), 128'(8'h15));
        chk("bad_addr_regs", 128'(regs), 128'h0000_0000_0000_0000_0000_0000_A500_0000);

        // TX FIFO full across a read response with the next frame already queued
        n0 = tx_log.size();
        tx_full = 1'b1;
        feed(8'h52); feed(8'h03); feed(8'h52); feed(8'h00);
        repeat (22) tick();
        chk("stall_no_push", 128'(tx_log.size()), 128'(n0));
        chk("stall_next_frame_held", 128'(rx_q.size()), 128'(2));
        chk("stall_w_data_held", 128'(w_data), 128'(8'hA5));
        tx_full = 1'b0;
        wait_idle(50);
        chk("stall_first_push", 128'(tx_log[n0]), 128'(8'hA5));
        chk("stall_second_push", 128'(tx_log[n0+1]), 128'(8'h00));

        // Reset in GET_DATA aborts the frame silently
        n0 = tx_log.size();
        feed(8'h57); feed(8'h05);
        budget = 0;
        while (frame_q.size() != 2 && budget < 10) begin
            tick();
            budget++;
        end
        chk("reached_get_data", 128'(frame_q.size()), 128'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("abort_no_push", 128'(tx_log.size()), 128'(n0));
        chk("abort_regs_cleared", 128'(regs), 128'(0));
        chk("abort_w_data_cleared", 128'(w_data), 128'(0));
        feed(8'h57); feed(8'h05); feed(8'h3C);
        feed(8'h52); feed(8'h05);
        wait_idle(60);
        chk("post_reset_write_ack", 128'(tx_log[n0]), 128'(8'h06));
        chk("post_reset_read", 128'(tx_log[n0+1]), 128'(8'h3C));
        chk("post_reset_regs", 128'(regs), 128'h0000_0000_0000_0000_0000_3C00_0000_0000);

`ifdef UART_RESP_TIMEOUT_EN
        // Starved partial write is dropped, register untouched
        n0 = tx_log.size();
        p0 = to_pulses;
        feed(8'h57); feed(8'h02);
        repeat (115) tick();
        chk("timeout_one_pulse", 128'(to_pulses - p0), 128'(1));
        chk("timeout_no_push", 128'(tx_log.size()), 128'(n0));
        feed(8'h52); feed(8'h02);
        wait_idle(50);
        chk("timeout_read_zero", 128'(tx_log[n0]), 128'(8'h00));
`endif

        // Randomized frame stream with random TX back-pressure and input gaps
        for (int f = 0; f < 200; f++) begin
            kind = $urandom_range(0, 9);
            fb.delete();
            if (kind < 4) begin
                fb.push_back(8'h52);
                fb.push_back(8'($urandom_range(0, 15)));
            end else if (kind < 8) begin
                fb.push_back(8'h57);
                fb.push_back(8'($urandom_range(0, 15)));
                fb.push_back(8'($urandom));
            end else if (kind == 8) begin
                fb.push_back(($urandom_range(0, 1) == 0) ? 8'h52 : 8'h57);
                fb.push_back(8'($urandom_range(16, 255)));
                if (fb[0] == 8'h57) fb.push_back(8'($urandom));
            end else begin
                b0 = 8'($urandom);
                if (b0 == 8'h52 || b0 == 8'h57) b0 = 8'h00;
                fb.push_back(b0);
            end
            foreach (fb[i]) begin
                feed(fb[i]);
                repeat ($urandom_range(0, 2)) begin
                    tx_full = ($urandom_range(0, 3) == 0);
                    tick();
                end
            end
        end
        tx_full = 1'b0;
        wait_idle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
